// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared types and constants for the AHB-Lite to APB3 bridge
package ahb_apb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_WRITE,
      ST_WENABLE,
      ST_READ,
      ST_RENABLE,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

endpackage

// File: rtl/ahb_apb_addr_decode.sv
// rtl/ahb_apb_addr_decode.sv - bridge region check and one-hot APB slave select
module ahb_apb_addr_decode
   import ahb_apb_pkg::*;
#(
   parameter int               ADDR_W    = 32,
   parameter int               NUM_SLV   = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] SLV_SPAN  = 32'h0400_0000
)(
   input  logic [ADDR_W-1:0]  addr,
   output logic               in_range,
   output logic [NUM_SLV-1:0] sel
);

   localparam int SPAN_SH = $clog2(SLV_SPAN);
   // One extra bit so a region ending exactly at the top of the address space does not wrap.
   localparam logic [ADDR_W:0] REGION = (ADDR_W+1)'(NUM_SLV) * {1'b0, SLV_SPAN};

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] slot;

   // Offset into the bridge window; the slave index is the offset in units of SLV_SPAN.
   always_comb begin
      offset   = addr - BASE_ADDR;
      slot     = offset >> SPAN_SH;
      in_range = (addr >= BASE_ADDR) && ({1'b0, offset} < REGION);
      sel      = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         sel[i] = in_range && (slot == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// rtl/ahb_apb_bridge_ctrl.sv - AHB-Lite slave to APB3 master bridge controller
module ahb_apb_bridge_ctrl
   import ahb_apb_pkg::*;
#(
   parameter int               ADDR_W    = 32,
   parameter int               DATA_W    = 32,
   parameter int               NUM_SLV   = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] SLV_SPAN  = 32'h0400_0000,
   parameter int               TIMEOUT   = 16
)(
   input  logic               clock,
   input  logic               Hresetn,
   input  logic [1:0]         Htrans,
   input  logic               Hwrite,
   input  logic               Hreadyin,
   input  logic [ADDR_W-1:0]  Haddr,
   input  logic [DATA_W-1:0]  Hwdata,
   input  logic [2:0]         Hsize,
   input  logic [2:0]         Hbrust,
   output logic               Hreadyout,
   output logic [1:0]         Hresp,
   output logic [DATA_W-1:0]  Hrdata,
   output logic [NUM_SLV-1:0] Psel,
   output logic               Penable,
   output logic               Pwrite,
   output logic [ADDR_W-1:0]  Paddr,
   output logic [DATA_W-1:0]  Pwdata,
   input  logic [DATA_W-1:0]  Prdata,
   input  logic               Pready
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   bridge_state_e      state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic [ADDR_W-1:0]  paddr_q;
   logic [DATA_W-1:0]  pwdata_q;
   logic               pwrite_q;
   logic [NUM_SLV-1:0] psel_q;

   logic               in_range;
   logic [NUM_SLV-1:0] dec_sel;
   logic               valid;
   logic               accept;
   logic               capture;
   logic               cnt_clr;
   logic               cnt_inc;

   // Only word, single-beat transfers are issued; size and burst type carry no information here.
   logic unused_inputs;
   assign unused_inputs = ^{Hsize, Hbrust};

   ahb_apb_addr_decode #(
      .ADDR_W    (ADDR_W),
      .NUM_SLV   (NUM_SLV),
      .BASE_ADDR (BASE_ADDR),
      .SLV_SPAN  (SLV_SPAN)
   ) u_decode (
      .addr     (Haddr),
      .in_range (in_range),
      .sel      (dec_sel)
   );

   assign valid = Hreadyin && in_range &&
                  ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));

   assign Paddr  = paddr_q;
   assign Pwdata = pwdata_q;
   assign Pwrite = pwrite_q & Hresetn;

   // State register.
   always_ff @(posedge clock) begin
      if (!Hresetn) state <= ST_IDLE;
      else          state <= state_n;
   end

   // Address/control latch on acceptance, write-data capture, and ACCESS wait counter.
   always_ff @(posedge clock) begin
      if (!Hresetn) begin
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         psel_q   <= '0;
         cnt      <= '0;
      end else begin
         if (accept) begin
            paddr_q  <= Haddr;
            pwrite_q <= Hwrite;
            psel_q   <= dec_sel;
         end
         if (capture) pwdata_q <= Hwdata;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;
      end
   end

   // Next state and bus outputs; the completing ACCESS cycle and ERR2 also accept a new transfer.
   always_comb begin
      state_n   = state;
      Hreadyout = 1'b1;
      Hresp     = RESP_OKAY;
      Hrdata    = '0;
      Psel      = '0;
      Penable   = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      if (Hresetn) begin
         case (state)
            ST_IDLE, ST_ERR2: begin
               if (state == ST_ERR2) Hresp = RESP_ERROR;
               accept  = valid;
               state_n = !valid ? ST_IDLE : (Hwrite ? ST_WWAIT : ST_READ);
            end
            ST_WWAIT: begin
               Hreadyout = 1'b0;
               capture   = 1'b1;
               state_n   = ST_WRITE;
            end
            ST_WRITE, ST_READ: begin
               Psel      = psel_q;
               Hreadyout = 1'b0;
               cnt_clr   = 1'b1;
               state_n   = (state == ST_WRITE) ? ST_WENABLE : ST_RENABLE;
            end
            ST_WENABLE, ST_RENABLE: begin
               Psel    = psel_q;
               Penable = 1'b1;
               if (Pready) begin
                  if (state == ST_RENABLE) Hrdata = Prdata;
                  accept  = valid;
                  state_n = !valid ? ST_IDLE : (Hwrite ? ST_WWAIT : ST_READ);
               end else begin
                  Hreadyout = 1'b0;
                  if (cnt == CNT_W'(TIMEOUT - 1)) state_n = ST_ERR1;
                  else                            cnt_inc = 1'b1;
               end
            end
            ST_ERR1: begin
               Hresp     = RESP_ERROR;
               Hreadyout = 1'b0;
               state_n   = ST_ERR2;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// tb/tb_ahb_apb_bridge_ctrl.sv - directed self-checking bench for ahb_apb_bridge_ctrl
module tb_ahb_apb_bridge_ctrl;

   logic        clock;
   logic        Hresetn;
   logic [1:0]  Htrans;
   logic        Hwrite;
   logic        Hreadyin;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [2:0]  Hsize;
   logic [2:0]  Hbrust;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;
   logic [3:0]  Psel;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        Pready;

   int total = 0;
   int bad   = 0;

   ahb_apb_bridge_ctrl dut (
      .clock     (clock),
      .Hresetn   (Hresetn),
      .Htrans    (Htrans),
      .Hwrite    (Hwrite),
      .Hreadyin  (Hreadyin),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Hsize     (Hsize),
      .Hbrust    (Hbrust),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata),
      .Psel      (Psel),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Prdata    (Prdata),
      .Pready    (Pready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic test_reset();
      Hresetn = 1'b0; Htrans = 2'b00; Hwrite = 1'b0; Hreadyin = 1'b1;
      Haddr = '0; Hwdata = '0; Hsize = 3'b010; Hbrust = 3'b000; Prdata = '0; Pready = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL reset_hreadyout: got %b want 1", Hreadyout); end
      total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL reset_hresp: got %b want 00", Hresp); end
      total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata: got %h want 0", Hrdata); end
      total++; if (Psel !== 4'b0000) begin bad++; $display("FAIL reset_psel: got %b want 0000", Psel); end
      total++; if (Penable !== 1'b0) begin bad++; $display("FAIL reset_penable: got %b want 0", Penable); end
      total++; if (Pwrite !== 1'b0) begin bad++; $display("FAIL reset_pwrite: got %b want 0", Pwrite); end
      total++; if (Paddr !== 32'h0) begin bad++; $display("FAIL reset_paddr: got %h want 0", Paddr); end
      total++; if (Pwdata !== 32'h0) begin bad++; $display("FAIL reset_pwdata: got %h want 0", Pwdata); end
      Hresetn = 1'b1;
   endtask

   task automatic test_single_write();
      int low_n = 0, psel_n = 0, psel_bad = 0;
      @(negedge clock);
      Htrans = 2'b10; Haddr = 32'h8000_0010; Hwrite = 1'b1; Pready = 1'b1;
      #1;
      total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL wr_addr_phase_ready: got %b want 1", Hreadyout); end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         Htrans = 2'b00; Hwrite = 1'b0; Haddr = '0;
         Hwdata = (k == 1) ? 32'hA5A5_A5A5 : 32'h0;
         #1;
         if (Hreadyout === 1'b0) low_n++;
         if (Psel !== 4'b0000) begin psel_n++; if (Psel !== 4'b0001) psel_bad++; end
         if (k == 2) begin
            total++; if (Penable !== 1'b0) begin bad++; $display("FAIL wr_setup_penable: got %b want 0", Penable); end
            total++; if (Pwdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wr_pwdata: got %h want a5a5a5a5", Pwdata); end
            total++; if (Paddr !== 32'h8000_0010) begin bad++; $display("FAIL wr_paddr: got %h want 80000010", Paddr); end
            total++; if (Pwrite !== 1'b1) begin bad++; $display("FAIL wr_pwrite: got %b want 1", Pwrite); end
         end
         if (k == 3) begin
            total++; if (Penable !== 1'b1) begin bad++; $display("FAIL wr_access_penable: got %b want 1", Penable); end
            total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL wr_done_ready: got %b want 1", Hreadyout); end
         end
      end
      total++; if (low_n !== 2) begin bad++; $display("FAIL wr_ready_low_cycles: got %0d want 2", low_n); end
      total++; if (psel_n !== 2) begin bad++; $display("FAIL wr_psel_cycles: got %0d want 2", psel_n); end
      total++; if (psel_bad !== 0) begin bad++; $display("FAIL wr_psel_value: got %0d wrong cycles want 0", psel_bad); end
   endtask

   task automatic test_read_wait();
      int low_n = 0, psel_n = 0, psel_bad = 0;
      @(negedge clock);
      Htrans = 2'b10; Haddr = 32'h8400_0004; Hwrite = 1'b0; Pready = 1'b0; Prdata = 32'h1234_5678;
      #1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         Htrans = 2'b00; Haddr = '0;
         Pready = (k == 5);
         #1;
         if (Hreadyout === 1'b0) low_n++;
         if (Psel !== 4'b0000) begin psel_n++; if (Psel !== 4'b0010) psel_bad++; end
         if (k == 3) begin
            total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL rd_hrdata_waiting: got %h want 0", Hrdata); end
         end
         if (k == 5) begin
            total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rd_done_ready: got %b want 1", Hreadyout); end
            total++; if (Hrdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_hrdata: got %h want 12345678", Hrdata); end
            total++; if (Penable !== 1'b1) begin bad++; $display("FAIL rd_penable: got %b want 1", Penable); end
         end
         if (k == 6) begin
            total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL rd_hrdata_idle: got %h want 0", Hrdata); end
         end
      end
      Pready = 1'b1;
      total++; if (low_n !== 4) begin bad++; $display("FAIL rd_ready_low_cycles: got %0d want 4", low_n); end
      total++; if (psel_n !== 5) begin bad++; $display("FAIL rd_psel_cycles: got %0d want 5", psel_n); end
      total++; if (psel_bad !== 0) begin bad++; $display("FAIL rd_psel_value: got %0d wrong cycles want 0", psel_bad); end
   endtask

   task automatic test_back_to_back();
      @(negedge clock);
      Htrans = 2'b10; Haddr = 32'h8000_0020; Hwrite = 1'b1; Pready = 1'b1;
      @(negedge clock);
      Htrans = 2'b00; Hwrite = 1'b0; Hwdata = 32'h0BAD_F00D;
      #1;
      total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL b2b_wwait_ready: got %b want 0", Hreadyout); end
      @(negedge clock);
      Hwdata = 32'h0;
      #1;
      total++; if (Psel !== 4'b0001 || Penable !== 1'b0) begin bad++; $display("FAIL b2b_wr_setup: got psel=%b en=%b want 0001/0", Psel, Penable); end
      @(negedge clock);
      Htrans = 2'b10; Haddr = 32'h8800_0008; Hwrite = 1'b0; Prdata = 32'hCAFE_0001;
      #1;
      total++; if (Psel !== 4'b0001 || Penable !== 1'b1 || Hreadyout !== 1'b1) begin bad++; $display("FAIL b2b_wr_access: got psel=%b en=%b rdy=%b want 0001/1/1", Psel, Penable, Hreadyout); end
      total++; if (Pwdata !== 32'h0BAD_F00D || Paddr !== 32'h8000_0020 || Pwrite !== 1'b1) begin bad++; $display("FAIL b2b_wr_latched: got %h %h %b want 0badf00d 80000020 1", Pwdata, Paddr, Pwrite); end
      @(negedge clock);
      Htrans = 2'b00; Haddr = '0;
      #1;
      total++; if (Psel !== 4'b0100 || Penable !== 1'b0 || Hreadyout !== 1'b0) begin bad++; $display("FAIL b2b_rd_setup: got psel=%b en=%b rdy=%b want 0100/0/0", Psel, Penable, Hreadyout); end
      total++; if (Paddr !== 32'h8800_0008 || Pwrite !== 1'b0) begin bad++; $display("FAIL b2b_rd_latched: got %h %b want 88000008 0", Paddr, Pwrite); end
      @(negedge clock);
      #1;
      total++; if (Penable !== 1'b1 || Hreadyout !== 1'b1 || Hrdata !== 32'hCAFE_0001) begin bad++; $display("FAIL b2b_rd_access: got en=%b rdy=%b data=%h want 1/1/cafe0001", Penable, Hreadyout, Hrdata); end
      @(negedge clock);
      #1;
      total++; if (Psel !== 4'b0000 || Hreadyout !== 1'b1) begin bad++; $display("FAIL b2b_idle: got psel=%b rdy=%b want 0000/1", Psel, Hreadyout); end
   endtask

   task automatic test_timeout();
      int en_n = 0, err_n = 0;
      @(negedge clock);
      Htrans = 2'b10; Haddr = 32'h8C00_0004; Hwrite = 1'b0; Pready = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clock);
         Htrans = 2'b00; Haddr = '0;
         #1;
         if (Penable === 1'b1) en_n++;
         if (Hresp === 2'b01) err_n++;
         if (k == 2) begin
            total++; if (Psel !== 4'b1000) begin bad++; $display("FAIL to_psel: got %b want 1000", Psel); end
         end
         if (k == 18) begin
            total++; if (Hresp !== 2'b01 || Hreadyout !== 1'b0 || Psel !== 4'b0000) begin bad++; $display("FAIL to_err1: got resp=%b rdy=%b psel=%b want 01/0/0000", Hresp, Hreadyout, Psel); end
         end
         if (k == 19) begin
            total++; if (Hresp !== 2'b01 || Hreadyout !== 1'b1) begin bad++; $display("FAIL to_err2: got resp=%b rdy=%b want 01/1", Hresp, Hreadyout); end
         end
         if (k == 20) begin
            total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL to_after: got resp=%b want 00", Hresp); end
         end
      end
      Pready = 1'b1;
      total++; if (en_n !== 16) begin bad++; $display("FAIL to_access_cycles: got %0d want 16", en_n); end
      total++; if (err_n !== 2) begin bad++; $display("FAIL to_err_cycles: got %0d want 2", err_n); end
   endtask

   task automatic test_ignored();
      logic [1:0]  tr_v [5] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b00};
      logic [31:0] ad_v [5] = '{32'h9000_0000, 32'h8000_0000, 32'h7FFF_FFFC, 32'h8000_0000, 32'h8000_0000};
      logic        rd_v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         Htrans = tr_v[i]; Haddr = ad_v[i]; Hreadyin = rd_v[i]; Hwrite = i[0];
         #1;
         total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL ign_addr_ready[%0d]: got %b want 1", i, Hreadyout); end
         @(negedge clock);
         Htrans = 2'b00; Haddr = '0; Hreadyin = 1'b1; Hwrite = 1'b0;
         #1;
         total++; if (Psel !== 4'b0000 || Hreadyout !== 1'b1 || Penable !== 1'b0) begin bad++; $display("FAIL ign_no_transfer[%0d]: got psel=%b rdy=%b en=%b want 0000/1/0", i, Psel, Hreadyout, Penable); end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      Htrans = 2'b10; Haddr = 32'h8000_0040; Hwrite = 1'b1; Pready = 1'b0;
      @(negedge clock);
      Htrans = 2'b00; Haddr = '0; Hwrite = 1'b0; Hwdata = 32'h1111_2222;
      @(negedge clock);
      Hwdata = '0;
      @(negedge clock);
      #1;
      total++; if (Penable !== 1'b1 || Psel !== 4'b0001) begin bad++; $display("FAIL rst_mid_access: got en=%b psel=%b want 1/0001", Penable, Psel); end
      Hresetn = 1'b0;
      @(negedge clock);
      Hresetn = 1'b1;
      #1;
      total++; if (Psel !== 4'b0000 || Penable !== 1'b0 || Hreadyout !== 1'b1 || Pwrite !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs: got psel=%b en=%b rdy=%b pw=%b want 0000/0/1/0", Psel, Penable, Hreadyout, Pwrite); end
      @(negedge clock);
      Htrans = 2'b10; Haddr = 32'h8400_0100; Hwrite = 1'b1; Pready = 1'b1;
      @(negedge clock);
      Htrans = 2'b00; Haddr = '0; Hwrite = 1'b0; Hwdata = 32'h3333_4444;
      @(negedge clock);
      Hwdata = '0;
      #1;
      total++; if (Psel !== 4'b0010 || Pwdata !== 32'h3333_4444 || Paddr !== 32'h8400_0100) begin bad++; $display("FAIL rst_after_setup: got psel=%b pwdata=%h paddr=%h want 0010/33334444/84000100", Psel, Pwdata, Paddr); end
      @(negedge clock);
      #1;
      total++; if (Penable !== 1'b1 || Hreadyout !== 1'b1) begin bad++; $display("FAIL rst_after_access: got en=%b rdy=%b want 1/1", Penable, Hreadyout); end
      @(negedge clock);
      #1;
      total++; if (Psel !== 4'b0000) begin bad++; $display("FAIL rst_after_idle: got psel=%b want 0000", Psel); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_wait();
      test_back_to_back();
      test_timeout();
      test_ignored();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
